// File: rtl/fft_out_streamer.sv
// Streams a captured 16-bin FFT result one bin per beat over a valid/ready port,
// with optional bit-reversed bin order and an |re|+|im| magnitude per beat.
module fft_out_streamer #(
  parameter int N      = 16,
  parameter int OUTW   = 48,
  parameter int BITREV = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture,
  input  logic [N*OUTW-1:0]      yr_flat,
  input  logic [N*OUTW-1:0]      yi_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_idx,
  output logic signed [OUTW-1:0] out_re,
  output logic signed [OUTW-1:0] out_im,
  output logic [OUTW:0]          out_mag,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   drop_err
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [3:0]             idx;
  logic [3:0]             idx_next;
  logic                   done_next;
  logic                   drop_next;
  logic [3:0]             sel;
  logic signed [OUTW-1:0] buf_re [N];
  logic signed [OUTW-1:0] buf_im [N];

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // One extra bit so that the most negative input maps to its true magnitude.
  function automatic logic [OUTW:0] abs_val(input logic signed [OUTW-1:0] v);
    logic [OUTW:0] ext;
    ext = {v[OUTW-1], v};
    if (v[OUTW-1]) begin
      return (~ext) + {{OUTW{1'b0}}, 1'b1};
    end else begin
      return ext;
    end
  endfunction

  // State, beat counter, flags and the snapshot buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 4'd0;
      done     <= 1'b0;
      drop_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      done     <= done_next;
      drop_err <= drop_next;
      if (state == IDLE && capture) begin
        for (int i = 0; i < N; i++) begin
          buf_re[i] <= yr_flat[i*OUTW +: OUTW];
          buf_im[i] <= yi_flat[i*OUTW +: OUTW];
        end
      end
    end
  end

  // Next-state: capture only from IDLE; captures during a stream are flagged.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    done_next  = 1'b0;
    drop_next  = drop_err;
    case (state)
      IDLE: begin
        if (capture) begin
          state_next = STREAM;
          idx_next   = 4'd0;
        end else begin
          state_next = IDLE;
        end
      end
      STREAM: begin
        if (capture) begin
          drop_next = 1'b1;
        end else begin
          drop_next = drop_err;
        end
        if (out_ready) begin
          if (idx == 4'd15) begin
            state_next = IDLE;
            idx_next   = 4'd0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx + 4'd1;
          end
        end else begin
          idx_next = idx;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 4'd0;
      end
    endcase
  end

  // Beat outputs are decoded straight from registered state and buffer.
  always_comb begin
    sel       = (BITREV == 1) ? bitrev4(idx) : idx;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_idx   = 4'd0;
    out_re    = '0;
    out_im    = '0;
    out_mag   = '0;
    out_last  = 1'b0;
    if (state == STREAM) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_idx   = idx;
      out_re    = buf_re[sel];
      out_im    = buf_im[sel];
      out_mag   = abs_val(buf_re[sel]) + abs_val(buf_im[sel]);
      out_last  = (idx == 4'd15);
    end else begin
      out_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_out_streamer.sv
// Scoreboard bench for fft_out_streamer: expected beats are queued at capture
// time and compared on every accepted beat; a second instance runs BITREV=1.
module tb_fft_out_streamer;
  localparam int N = 16;
  localparam int W = 48;

  typedef struct {
    logic [63:0] idx;
    logic [63:0] re;
    logic [63:0] im;
    logic [63:0] mag;
    logic [63:0] last;
  } beat_t;

  logic             clk;
  logic             rst;
  logic             capture;
  logic [N*W-1:0]   yr;
  logic [N*W-1:0]   yi;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_idx;
  logic [W-1:0]     out_re;
  logic [W-1:0]     out_im;
  logic [W:0]       out_mag;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             drop_err;

  logic             cap_br;
  logic [N*W-1:0]   yr_br;
  logic [N*W-1:0]   yi_br;
  logic             valid_br;
  logic             ready_br;
  logic [3:0]       idx_br;
  logic [W-1:0]     re_br;
  logic [W-1:0]     im_br;
  logic [W:0]       mag_br;
  logic             last_br;
  logic             busy_br;
  logic             done_br;
  logic             drop_br;

  int    checks = 0;
  int    failures = 0;
  beat_t sb[$];
  logic  hold_pending = 1'b0;
  logic [3:0]   held_idx;
  logic [W-1:0] held_re;
  logic [W-1:0] held_im;
  logic         held_last;

  fft_out_streamer #(.N(N), .OUTW(W), .BITREV(0)) dut (
    .clk(clk), .rst(rst), .capture(capture), .yr_flat(yr), .yi_flat(yi),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_re(out_re), .out_im(out_im), .out_mag(out_mag), .out_last(out_last),
    .busy(busy), .done(done), .drop_err(drop_err)
  );

  fft_out_streamer #(.N(N), .OUTW(W), .BITREV(1)) dut_br (
    .clk(clk), .rst(rst), .capture(cap_br), .yr_flat(yr_br), .yi_flat(yi_br),
    .out_valid(valid_br), .out_ready(ready_br), .out_idx(idx_br),
    .out_re(re_br), .out_im(im_br), .out_mag(mag_br), .out_last(last_br),
    .busy(busy_br), .done(done_br), .drop_err(drop_br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  function automatic logic [63:0] sext(input logic [W-1:0] v);
    logic signed [W-1:0] s;
    longint l;
    s = v;
    l = s;
    return l;
  endfunction

  function automatic longint absl(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Queue the 16 beats a capture of (r, i) must produce, in natural order.
  task automatic push_stream(input logic [N*W-1:0] r, input logic [N*W-1:0] i);
    beat_t  b;
    longint lr;
    longint li;
    for (int k = 0; k < N; k++) begin
      lr     = longint'(sext(r[k*W +: W]));
      li     = longint'(sext(i[k*W +: W]));
      b.idx  = k;
      b.re   = lr;
      b.im   = li;
      b.mag  = absl(lr) + absl(li);
      b.last = (k == N - 1) ? 64'd1 : 64'd0;
      sb.push_back(b);
    end
  endtask

  // Scoreboard compare on every accepted beat, plus hold-stability under backpressure.
  always @(negedge clk) begin
    beat_t b;
    if (out_valid && hold_pending) begin
      check_eq("hold_idx", {60'd0, out_idx}, {60'd0, held_idx});
      check_eq("hold_re", sext(out_re), sext(held_re));
      check_eq("hold_im", sext(out_im), sext(held_im));
      check_eq("hold_last", {63'd0, out_last}, {63'd0, held_last});
    end
    hold_pending = out_valid && !out_ready && !rst;
    held_idx  = out_idx;
    held_re   = out_re;
    held_im   = out_im;
    held_last = out_last;
    if (out_valid && out_ready) begin
      check_eq("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        check_eq("beat_idx", {60'd0, out_idx}, b.idx);
        check_eq("beat_re", sext(out_re), b.re);
        check_eq("beat_im", sext(out_im), b.im);
        check_eq("beat_mag", {15'd0, out_mag}, b.mag);
        check_eq("beat_last", {63'd0, out_last}, b.last);
      end
    end
  end

  function automatic logic rdy(input int mode, input int c);
    return (mode == 0) ? 1'b1 : ((c % 2) == 0);
  endfunction

  // Enter with capture set just after a rising edge; runs a fixed number of cycles.
  task automatic run_stream(input int mode, input int drop_at, input int rst_at,
                            input int limit, output int done_at, output int done_cnt);
    done_at  = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    capture   = 1'b0;
    out_ready = rdy(mode, 1);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = c;
          check_eq("busy_at_done", {63'd0, busy}, 64'd0);
        end
      end
      if (rst_at != 0 && c == rst_at + 1) begin
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
      end
      @(posedge clk); #1;
      capture   = 1'b0;
      rst       = 1'b0;
      out_ready = rdy(mode, c + 1);
      if (c + 1 == drop_at) begin
        capture = 1'b1;
        for (int k = 0; k < N; k++) begin
          yr[k*W +: W] = rnd48();
          yi[k*W +: W] = rnd48();
        end
      end
      if (c + 1 == rst_at) rst = 1'b1;
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) begin
      yr[k*W +: W] = rnd48();
      yi[k*W +: W] = rnd48();
    end
  endtask

  initial begin
    int dat;
    int dcnt;
    logic [W-1:0] v;
    rst = 1'b1; capture = 1'b0; out_ready = 1'b0; yr = '0; yi = '0;
    cap_br = 1'b0; ready_br = 1'b1; yr_br = '0; yi_br = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid0", {63'd0, out_valid}, 64'd0);
    check_eq("rst_busy0", {63'd0, busy}, 64'd0);
    check_eq("rst_done0", {63'd0, done}, 64'd0);
    check_eq("rst_drop0", {63'd0, drop_err}, 64'd0);
    check_eq("rst_idx0", {60'd0, out_idx}, 64'd0);
    check_eq("rst_mag0", {15'd0, out_mag}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Impulse, ready always high.
    yr = '0; yi = '0;
    v = 48'd16000;
    yr[0 +: W] = v;
    capture = 1'b1;
    push_stream(yr, yi);
    run_stream(0, 0, 0, 24, dat, dcnt);
    check_eq("imp_done_at", dat, 17);
    check_eq("imp_done_cnt", dcnt, 1);
    check_eq("imp_sb_empty", sb.size(), 0);

    // Backpressure 0,1,0,1...: each beat takes two cycles.
    rand_data();
    capture = 1'b1;
    push_stream(yr, yi);
    run_stream(1, 0, 0, 40, dat, dcnt);
    check_eq("bp_done_at", dat, 33);
    check_eq("bp_done_cnt", dcnt, 1);
    check_eq("bp_sb_empty", sb.size(), 0);

    // Capture with new data while beat 7 is presented must be dropped.
    check_eq("drop_before", {63'd0, drop_err}, 64'd0);
    rand_data();
    capture = 1'b1;
    push_stream(yr, yi);
    run_stream(0, 8, 0, 24, dat, dcnt);
    check_eq("drop_done_at", dat, 17);
    check_eq("drop_flag", {63'd0, drop_err}, 64'd1);
    check_eq("drop_sb_empty", sb.size(), 0);

    // Reset while beat 5 is presented: no done, flags cleared.
    rand_data();
    capture = 1'b1;
    push_stream(yr, yi);
    run_stream(0, 0, 6, 24, dat, dcnt);
    check_eq("rst_done_cnt", dcnt, 0);
    check_eq("rst_drop_clr", {63'd0, drop_err}, 64'd0);
    sb.delete();

    // Fresh capture after reset with the magnitude corner in bin 0.
    rand_data();
    v = 48'h8000_0000_0000;
    yr[0 +: W] = v;
    v = 48'hFFFF_FFFF_FFFF;
    yi[0 +: W] = v;
    capture = 1'b1;
    push_stream(yr, yi);
    @(posedge clk); #1;
    capture = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("mag_corner", {15'd0, out_mag}, 64'h0000_8000_0000_0001);
    check_eq("fresh_idx0", {60'd0, out_idx}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    check_eq("fresh_sb_empty", sb.size(), 0);

    // Bit-reversed instance: bin k holds re=k.
    for (int k = 0; k < N; k++) yr_br[k*W +: W] = k;
    cap_br = 1'b1;
    @(posedge clk); #1;
    cap_br = 1'b0;
    @(negedge clk);
    check_eq("br_idx0", {60'd0, idx_br}, 64'd0);
    check_eq("br_re0", sext(re_br), 64'd0);
    @(negedge clk);
    check_eq("br_idx1", {60'd0, idx_br}, 64'd1);
    check_eq("br_re1", sext(re_br), 64'd8);
    repeat (2) @(negedge clk);
    check_eq("br_idx3", {60'd0, idx_br}, 64'd3);
    check_eq("br_re3", sext(re_br), 64'd12);
    check_eq("br_mag3", {15'd0, mag_br}, 64'd12);
    repeat (14) @(negedge clk);
    check_eq("br_idle", {63'd0, valid_br}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_out_streamer.md
FFT_OUT_STREAMER -- requirements
Module: fft_out_streamer

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter N, default 16, giving the number of FFT bins; only the value 16 is required to be supported.
REQ-002 The block SHALL have parameter OUTW, default 48, giving the signed width of each real and imaginary bin value.
REQ-003 The block SHALL have parameter BITREV, default 0; when set to 1, beat k SHALL emit bin bitrev4(k).

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have a port named clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have a port named rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have a port named capture, input, 1 bit, a request to snapshot the FFT results.
REQ-007 The block SHALL have a port named yr_flat, input, N*OUTW bits, carrying the signed real part of each bin; bin i occupies bits [i*OUTW +: OUTW].
REQ-008 The block SHALL have a port named yi_flat, input, N*OUTW bits, carrying the signed imaginary part of each bin, packed the same way as yr_flat.
REQ-009 The block SHALL have a port named out_valid, output, 1 bit, asserted when a beat is presented.
REQ-010 The block SHALL have a port named out_ready, input, 1 bit, the consumer's acceptance signal.
REQ-011 The block SHALL have a port named out_idx, output, 4 bits, the beat number, 0 to 15.
REQ-012 The block SHALL have a port named out_re, output, OUTW bits, signed, the real part of the current bin.
REQ-013 The block SHALL have a port named out_im, output, OUTW bits, signed, the imaginary part of the current bin.
REQ-014 The block SHALL have a port named out_mag, output, OUTW+1 bits, unsigned, equal to |re| + |im| for the current bin.
REQ-015 The block SHALL have a port named out_last, output, 1 bit, asserted with beat 15.
REQ-016 The block SHALL have a port named busy, output, 1 bit, high while the block is in the STREAM state.
REQ-017 The block SHALL have a port named done, output, 1 bit, a one-cycle pulse after the final beat is accepted.
REQ-018 The block SHALL have a port named drop_err, output, 1 bit, a sticky flag recording a rejected capture.

Function
REQ-019 The block SHALL implement the states IDLE and STREAM.
REQ-020 In IDLE, when capture=1, the block SHALL register all of yr_flat and yi_flat into an internal 16-entry buffer on that edge, set the beat counter to 0, and enter STREAM.
REQ-021 Latency: out_valid SHALL be high in the cycle immediately after the capture edge.
REQ-022 In STREAM, out_valid and busy SHALL both be 1.
REQ-023 In STREAM, out_re, out_im and out_mag SHALL reflect buffer entry sel, where sel = idx when BITREV=0 and sel = bitrev4(idx) when BITREV=1.
REQ-024 In STREAM, out_idx SHALL equal idx.
REQ-025 A handshake SHALL occur when out_valid=1 and out_ready=1 at a rising edge.
REQ-026 On a handshake with idx<15, the beat counter SHALL increment by 1.
REQ-027 On a handshake with idx=15, the block SHALL return to IDLE and assert done for exactly the next cycle.
REQ-028 While out_valid=1 and out_ready=0, out_idx, out_re, out_im, out_mag and out_last SHALL hold stable.
REQ-029 out_ready SHALL be permitted to be 1 before out_valid rises; with out_ready held at 1 the stream SHALL complete in 16 consecutive cycles.
REQ-030 out_last SHALL equal out_valid AND (idx==15).
REQ-031 out_mag SHALL be computed without overflow; the value -2^(OUTW-1) SHALL yield magnitude 2^(OUTW-1).
REQ-032 A capture asserted in STREAM, including in the cycle of the final handshake, SHALL be ignored, SHALL set drop_err, and SHALL NOT alter the buffer or the beat counter.
REQ-033 drop_err SHALL remain set until rst.
REQ-034 Changes on yr_flat or yi_flat after the capture edge SHALL NOT affect emitted data.
REQ-035 In IDLE, out_valid, out_last and busy SHALL be 0; out_idx, out_re, out_im and out_mag SHALL be 0.
REQ-036 A capture in the cycle done is high SHALL be accepted, starting a new stream.

Reset
REQ-037 When rst=1 at a rising edge, the state SHALL become IDLE, the beat counter and buffer SHALL clear to 0, and all outputs SHALL be 0 in the following cycle.
REQ-038 rst SHALL take priority over capture and over any handshake.
REQ-039 A reset during STREAM SHALL abort the stream without asserting done.

Verification
REQ-040 Bench SHALL cover impulse: bin0 re=16000, all others 0, out_ready=1 -> 16 beats on consecutive cycles; beat 0 re=16000, mag=16000; beats 1-15 re=im=mag=0; out_last on beat 15; done one cycle later; busy low.
REQ-041 Bench SHALL cover backpressure: out_ready pattern 1,0 repeating -> each beat held 2 cycles with stable data; done 32 cycles after stream start.
REQ-042 Bench SHALL cover drop: capture pulsed at beat 7 with new data -> drop_err=1; beats 7-15 carry the original capture values.
REQ-043 Bench SHALL cover magnitude corner: re=-2^47, im=-1 -> out_mag=2^47+1, no wrap.
REQ-044 Bench SHALL cover BITREV=1: bin k holds re=k -> beat 1 shows out_idx=1, re=8; beat 3 shows re=12.
REQ-045 Bench SHALL cover reset mid-stream: rst at beat 5 -> out_valid=0 in the next cycle, done never pulses, drop_err=0; a fresh capture afterwards starts again at beat 0.
